// File: rtl/pint_host_bridge.sv
// Host-link framing bridge in front of the PINT serial interface: forwards host write/command
// frames to the TX FIFO, returns PINT read data as response frames and reports ACK/NAK.
module pint_host_bridge #(
    parameter int unsigned RX_DEPTH  = 64,
    parameter int unsigned TO_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] host_char,
    input  logic       host_valid,
    output logic       host_ready,
    output logic [7:0] out_char,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] tx_char,
    output logic       tx_char_latch,
    output logic       tx_req,
    output logic       tx_cmd_type,
    input  logic       pint_busy,
    input  logic [7:0] rx_data,
    input  logic       rx_latch,
    input  logic       rx_req
);
    localparam int unsigned TW = $clog2(TO_CYCLES);
    localparam int unsigned IW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam logic [7:0] CH_W = 8'h57;
    localparam logic [7:0] CH_C = 8'h43;
    localparam logic [7:0] CH_R = 8'h52;
    localparam logic [7:0] ACK  = 8'h2E;
    localparam logic [7:0] NAK  = 8'h21;

    typedef enum logic [2:0] {T_TYPE, T_LEN, T_DATA, T_WAITIDLE, T_REQ, T_START, T_DONE} tx_state_t;
    typedef enum logic [2:0] {O_IDLE, O_HDR, O_LEN, O_DATA, O_CODE} out_state_t;

    tx_state_t  tx_state, tx_nxt;
    out_state_t o_state;
    logic [7:0]    byte_cnt;
    logic [TW-1:0] to_cnt;
    logic          cmd_type;
    logic          pend, pend_nxt, pend_set;
    logic [7:0]    pend_code, code_new;
    logic [6:0]    rx_cnt, idx;
    logic          rx_drop, drop_late, rx_ready;
    logic [7:0]    rx_mem [RX_DEPTH];

    logic host_acc, to_hit, rx_full, frame_done_c, pend_clr_c;
    assign host_acc     = host_valid & host_ready;
    assign to_hit       = (to_cnt == TW'(TO_CYCLES - 1));
    assign rx_full      = (rx_cnt == 7'(RX_DEPTH));
    assign frame_done_c = out_ready && ((o_state == O_LEN && rx_cnt == 7'd0) ||
                                        (o_state == O_DATA && idx == rx_cnt));
    assign pend_clr_c   = out_ready && (o_state == O_CODE);

    // TX next state and ACK/NAK queueing
    always_comb begin
        tx_nxt   = tx_state;
        pend_set = 1'b0;
        code_new = NAK;
        case (tx_state)
            T_TYPE: if (host_acc) begin
                if (host_char == CH_W || host_char == CH_C) tx_nxt = T_LEN;
                else pend_set = 1'b1;
            end
            T_LEN: if (host_acc) begin
                if (host_char == 8'd0) begin
                    pend_set = 1'b1;
                    tx_nxt   = T_TYPE;
                end else begin
                    tx_nxt = T_DATA;
                end
            end
            T_DATA:     if (host_acc && byte_cnt == 8'd1) tx_nxt = T_WAITIDLE;
            T_WAITIDLE: if (!pint_busy) tx_nxt = T_REQ;
            T_REQ:      tx_nxt = T_START;
            T_START: begin
                if (pint_busy) tx_nxt = T_DONE;
                else if (to_hit) begin
                    pend_set = 1'b1;
                    tx_nxt   = T_TYPE;
                end
            end
            T_DONE: begin
                if (!pint_busy) begin
                    pend_set = 1'b1;
                    code_new = ACK;
                    tx_nxt   = T_TYPE;
                end else if (to_hit) begin
                    pend_set = 1'b1;
                    tx_nxt   = T_TYPE;
                end
            end
            default: tx_nxt = T_TYPE;
        endcase
        pend_nxt = pend_set ? 1'b1 : (pend_clr_c ? 1'b0 : pend);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state      <= T_TYPE;
            host_ready    <= 1'b0;
            tx_char       <= 8'd0;
            tx_char_latch <= 1'b0;
            tx_req        <= 1'b0;
            tx_cmd_type   <= 1'b0;
            cmd_type      <= 1'b0;
            byte_cnt      <= 8'd0;
            to_cnt        <= '0;
            pend          <= 1'b0;
            pend_code     <= 8'd0;
        end else begin
            tx_state      <= tx_nxt;
            pend          <= pend_nxt;
            tx_char_latch <= 1'b0;
            tx_req        <= 1'b0;
            if (pend_set) pend_code <= code_new;
            host_ready <= (tx_nxt == T_TYPE || tx_nxt == T_LEN || tx_nxt == T_DATA) && !pend_nxt;
            if (host_acc) begin
                case (tx_state)
                    T_TYPE: cmd_type <= (host_char == CH_C);
                    T_LEN:  byte_cnt <= host_char;
                    T_DATA: begin
                        tx_char       <= host_char;
                        tx_char_latch <= 1'b1;
                        byte_cnt      <= byte_cnt - 8'd1;
                    end
                    default: ;
                endcase
            end
            // request is high exactly while the FSM sits in T_REQ
            if (tx_state == T_WAITIDLE && tx_nxt == T_REQ) begin
                tx_req      <= 1'b1;
                tx_cmd_type <= cmd_type;
            end
            if (tx_state == T_REQ) to_cnt <= '0;
            else if ((tx_state == T_START || tx_state == T_DONE) && !to_hit) to_cnt <= to_cnt + TW'(1);
        end
    end

    // RX capture; drops during an outstanding frame are charged to the following frame
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_cnt    <= 7'd0;
            rx_drop   <= 1'b0;
            drop_late <= 1'b0;
            rx_ready  <= 1'b0;
        end else if (rx_ready) begin
            if (frame_done_c) begin
                rx_cnt    <= 7'd0;
                rx_drop   <= drop_late | rx_latch;
                drop_late <= 1'b0;
                rx_ready  <= 1'b0;
            end else if (rx_latch) begin
                drop_late <= 1'b1;
            end
        end else begin
            if (rx_latch) begin
                if (rx_full) rx_drop <= 1'b1;
                else rx_cnt <= rx_cnt + 7'd1;
            end
            if (rx_req && (rx_cnt != 7'd0 || rx_drop || rx_latch)) rx_ready <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rx_ready && rx_latch && !rx_full) rx_mem[rx_cnt[IW-1:0]] <= rx_data;
    end

    // Output arbiter: response frames before ACK/NAK, never interleaved
    always_ff @(posedge clk) begin
        if (reset) begin
            o_state   <= O_IDLE;
            out_valid <= 1'b0;
            out_char  <= 8'd0;
            idx       <= 7'd0;
        end else begin
            case (o_state)
                O_IDLE: begin
                    if (rx_ready) begin
                        out_char  <= CH_R;
                        out_valid <= 1'b1;
                        o_state   <= O_HDR;
                    end else if (pend) begin
                        out_char  <= pend_code;
                        out_valid <= 1'b1;
                        o_state   <= O_CODE;
                    end
                end
                O_HDR: if (out_ready) begin
                    out_char <= {rx_drop, rx_cnt};
                    o_state  <= O_LEN;
                end
                O_LEN: if (out_ready) begin
                    if (rx_cnt == 7'd0) begin
                        out_valid <= 1'b0;
                        o_state   <= O_IDLE;
                    end else begin
                        out_char <= rx_mem[0];
                        idx      <= 7'd1;
                        o_state  <= O_DATA;
                    end
                end
                O_DATA: if (out_ready) begin
                    if (idx == rx_cnt) begin
                        out_valid <= 1'b0;
                        o_state   <= O_IDLE;
                    end else begin
                        out_char <= rx_mem[idx[IW-1:0]];
                        idx      <= idx + 7'd1;
                    end
                end
                O_CODE: if (out_ready) begin
                    out_valid <= 1'b0;
                    o_state   <= O_IDLE;
                end
                default: o_state <= O_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pint_host_bridge.sv
// Directed bench for pint_host_bridge: host frames, PINT handshakes, read-back frames, timeouts, reset.
module tb_pint_host_bridge;
    localparam int unsigned RXD = 4;
    localparam int unsigned TO  = 300;

    logic       clk, reset;
    logic [7:0] host_char;
    logic       host_valid, host_ready;
    logic [7:0] out_char;
    logic       out_valid, out_ready;
    logic [7:0] tx_char;
    logic       tx_char_latch, tx_req, tx_cmd_type, pint_busy;
    logic [7:0] rx_data;
    logic       rx_latch, rx_req;

    int errors = 0;
    int checks = 0;

    pint_host_bridge #(.RX_DEPTH(RXD), .TO_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .host_char(host_char), .host_valid(host_valid), .host_ready(host_ready),
        .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready),
        .tx_char(tx_char), .tx_char_latch(tx_char_latch), .tx_req(tx_req), .tx_cmd_type(tx_cmd_type),
        .pint_busy(pint_busy), .rx_data(rx_data), .rx_latch(rx_latch), .rx_req(rx_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observation recorders, sampled mid-cycle
    logic [7:0] out_q[$];
    logic [7:0] lat_q[$];
    logic       cmd_q[$];
    int         req_n = 0;
    int         cyc = 0;
    int         stab_err = 0;
    logic       hold = 1'b0;
    logic [7:0] held = 8'd0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            hold = 1'b0;
        end else begin
            if (hold && (!out_valid || out_char != held)) stab_err++;
            hold = out_valid && !out_ready;
            held = out_char;
            if (out_valid && out_ready) out_q.push_back(out_char);
            if (tx_char_latch) lat_q.push_back(tx_char);
            if (tx_req) begin
                req_n++;
                cmd_q.push_back(tx_cmd_type);
            end
        end
    end

    function automatic logic [7:0] outb(int i);
        return (i < out_q.size()) ? out_q[i] : 8'hxx;
    endfunction
    function automatic logic [7:0] latb(int i);
        return (i < lat_q.size()) ? lat_q[i] : 8'hxx;
    endfunction
    function automatic logic cmdb(int i);
        return (i < cmd_q.size()) ? cmd_q[i] : 1'bx;
    endfunction

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(logic [7:0] b);
        int k = 0;
        host_char  = b;
        host_valid = 1'b1;
        while (!host_ready && k < 2000) begin
            tick(1);
            k++;
        end
        if (!host_ready) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: host_ready=%b for byte %h, required 1", host_ready, b);
        end
        tick(1);
        host_valid = 1'b0;
    endtask

    task automatic wait_out(int n, int budget);
        int k = 0;
        while (out_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        if (out_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL wait_out_timeout: got %0d bytes, required %0d", out_q.size(), n);
        end
    endtask

    task automatic wait_req(int n, int budget);
        int k = 0;
        while (req_n < n && k < budget) begin
            tick(1);
            k++;
        end
        if (req_n < n) begin
            checks++;
            errors++;
            $display("FAIL wait_req_timeout: got %0d tx_req, required %0d", req_n, n);
        end
    endtask

    task automatic rx_byte(logic [7:0] b);
        rx_data  = b;
        rx_latch = 1'b1;
        tick(1);
        rx_latch = 1'b0;
    endtask

    task automatic rx_close();
        rx_req = 1'b1;
        tick(1);
        rx_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++;
        if ({host_ready, out_valid, out_char, tx_char, tx_char_latch, tx_req, tx_cmd_type} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b %b %h %h %b %b %b, required all 0", host_ready, out_valid,
                     out_char, tx_char, tx_char_latch, tx_req, tx_cmd_type);
        end
        reset = 1'b0;
        tick(2);
        checks++;
        if (host_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: host_ready=%b, required 1", host_ready);
        end
    endtask

    task automatic test_write();
        int l0 = lat_q.size();
        int r0 = req_n;
        int o0 = out_q.size();
        send_byte(8'h57); send_byte(8'h02); send_byte(8'hAA); send_byte(8'h55);
        wait_req(r0 + 1, 50);
        checks++;
        if (lat_q.size() !== l0 + 2) begin
            errors++;
            $display("FAIL write_latch_count: got %0d, required %0d", lat_q.size() - l0, 2);
        end
        checks++;
        if (latb(l0) !== 8'hAA) begin errors++; $display("FAIL write_byte0: got %h, required AA", latb(l0)); end
        checks++;
        if (latb(l0 + 1) !== 8'h55) begin errors++; $display("FAIL write_byte1: got %h, required 55", latb(l0 + 1)); end
        checks++;
        if (cmdb(r0) !== 1'b0) begin errors++; $display("FAIL write_cmd_type: got %b, required 0", cmdb(r0)); end
        pint_busy = 1'b1;
        tick(100);
        pint_busy = 1'b0;
        wait_out(o0 + 1, 50);
        checks++;
        if (outb(o0) !== 8'h2E) begin errors++; $display("FAIL write_ack: got %h, required 2E", outb(o0)); end
        checks++;
        if (req_n !== r0 + 1) begin errors++; $display("FAIL write_req_count: got %0d, required %0d", req_n - r0, 1); end
    endtask

    task automatic test_cmd_and_nak();
        int l0 = lat_q.size();
        int r0 = req_n;
        int o0 = out_q.size();
        int l1;
        send_byte(8'h43); send_byte(8'h01); send_byte(8'h3C);
        wait_req(r0 + 1, 50);
        checks++;
        if (cmdb(r0) !== 1'b1) begin errors++; $display("FAIL cmd_type: got %b, required 1", cmdb(r0)); end
        checks++;
        if (latb(l0) !== 8'h3C) begin errors++; $display("FAIL cmd_byte: got %h, required 3C", latb(l0)); end
        pint_busy = 1'b1;
        tick(5);
        pint_busy = 1'b0;
        wait_out(o0 + 1, 50);
        checks++;
        if (outb(o0) !== 8'h2E) begin errors++; $display("FAIL cmd_ack: got %h, required 2E", outb(o0)); end
        l1 = lat_q.size();
        send_byte(8'h10);
        wait_out(o0 + 2, 50);
        checks++;
        if (outb(o0 + 1) !== 8'h21) begin errors++; $display("FAIL nak_type: got %h, required 21", outb(o0 + 1)); end
        send_byte(8'h57); send_byte(8'h00);
        wait_out(o0 + 3, 50);
        checks++;
        if (outb(o0 + 2) !== 8'h21) begin errors++; $display("FAIL nak_len0: got %h, required 21", outb(o0 + 2)); end
        tick(5);
        checks++;
        if (lat_q.size() !== l1) begin errors++; $display("FAIL nak_no_latch: got %0d latches, required 0", lat_q.size() - l1); end
        checks++;
        if (req_n !== r0 + 1) begin errors++; $display("FAIL nak_no_req: got %0d tx_req, required 1", req_n - r0); end
    endtask

    task automatic test_rx();
        int o0 = out_q.size();
        logic [7:0] exp [5];
        exp = '{8'h52, 8'h03, 8'h11, 8'h22, 8'h33};
        rx_byte(8'h11); rx_byte(8'h22); rx_byte(8'h33);
        rx_close();
        wait_out(o0 + 5, 50);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (outb(o0 + i) !== exp[i]) begin
                errors++;
                $display("FAIL rx_frame_byte%0d: got %h, required %h", i, outb(o0 + i), exp[i]);
            end
        end
        rx_close();
        tick(20);
        checks++;
        if (out_q.size() !== o0 + 5) begin
            errors++;
            $display("FAIL rx_empty_req: got %0d extra bytes, required 0", out_q.size() - (o0 + 5));
        end
    endtask

    task automatic test_overflow();
        int o0 = out_q.size();
        logic [7:0] exp [6];
        exp = '{8'h52, 8'h84, 8'h01, 8'h02, 8'h03, 8'h04};
        for (int i = 1; i <= 6; i++) rx_byte(8'(i));
        rx_close();
        wait_out(o0 + 6, 50);
        tick(10);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (outb(o0 + i) !== exp[i]) begin
                errors++;
                $display("FAIL ovf_byte%0d: got %h, required %h", i, outb(o0 + i), exp[i]);
            end
        end
        checks++;
        if (out_q.size() !== o0 + 6) begin
            errors++;
            $display("FAIL ovf_length: got %0d bytes, required 6", out_q.size() - o0);
        end
    endtask

    task automatic test_timeout();
        for (int mode = 0; mode < 2; mode++) begin
            int r0 = req_n;
            int o0 = out_q.size();
            int c0;
            int el;
            send_byte(8'h57); send_byte(8'h01); send_byte(8'h77);
            wait_req(r0 + 1, 50);
            c0 = cyc;
            pint_busy = (mode == 0);
            wait_out(o0 + 1, TO + 100);
            el = cyc - c0;
            pint_busy = 1'b0;
            checks++;
            if (outb(o0) !== 8'h21) begin
                errors++;
                $display("FAIL timeout_nak_busy%0d: got %h, required 21", 1 - mode, outb(o0));
            end
            checks++;
            if ((el >= TO - 5 && el <= TO + 20) !== 1'b1) begin
                errors++;
                $display("FAIL timeout_latency_busy%0d: got %0d cycles, required about %0d", 1 - mode, el, TO);
            end
            tick(3);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        int o0;
        int l0;
        int r0;
        send_byte(8'h57); send_byte(8'h03); send_byte(8'h01);
        rx_byte(8'hC1); rx_byte(8'hC2); rx_byte(8'hC3);
        rx_close();
        o0 = out_q.size();
        while (out_q.size() < o0 + 3 && k < 100) begin
            out_ready = ~out_ready;
            tick(1);
            k++;
        end
        reset = 1'b1;
        tick(1);
        checks++;
        if ({host_ready, out_valid, out_char, tx_char, tx_char_latch, tx_req, tx_cmd_type} !== 21'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b %b %h %h %b %b %b, required all 0", host_ready, out_valid,
                     out_char, tx_char, tx_char_latch, tx_req, tx_cmd_type);
        end
        reset = 1'b0;
        out_ready = 1'b1;
        tick(2);
        o0 = out_q.size();
        l0 = lat_q.size();
        r0 = req_n;
        checks++;
        if (host_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b, required 1", host_ready); end
        send_byte(8'h57); send_byte(8'h01); send_byte(8'h99);
        wait_req(r0 + 1, 50);
        checks++;
        if (latb(l0) !== 8'h99) begin errors++; $display("FAIL midreset_tx: got %h, required 99", latb(l0)); end
        pint_busy = 1'b1;
        tick(4);
        pint_busy = 1'b0;
        wait_out(o0 + 1, 50);
        checks++;
        if (outb(o0) !== 8'h2E) begin errors++; $display("FAIL midreset_ack: got %h, required 2E", outb(o0)); end
        rx_byte(8'hA5);
        rx_close();
        wait_out(o0 + 4, 50);
        checks++;
        if ({outb(o0 + 1), outb(o0 + 2), outb(o0 + 3)} !== 24'h5201A5) begin
            errors++;
            $display("FAIL midreset_rx: got %h %h %h, required 52 01 A5", outb(o0 + 1), outb(o0 + 2), outb(o0 + 3));
        end
    endtask

    task automatic test_out_hold();
        checks++;
        if (stab_err !== 0) begin
            errors++;
            $display("FAIL out_hold_stable: got %0d unstable cycles, required 0", stab_err);
        end
    endtask

    initial begin
        reset      = 1'b1;
        host_char  = 8'd0;
        host_valid = 1'b0;
        out_ready  = 1'b1;
        pint_busy  = 1'b0;
        rx_data    = 8'd0;
        rx_latch   = 1'b0;
        rx_req     = 1'b0;
        test_reset();
        test_write();
        test_cmd_and_nak();
        test_rx();
        test_overflow();
        test_timeout();
        test_reset_mid();
        test_out_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
